// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter for four IoT event requesters feeding an active-device counter.
// Optional boundary rejection is enabled with macro IOT_ARB_REJECT_EN.
module iot_event_arbiter #(
    parameter logic [7:0] MAX_DEVICES = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] dir,
    output logic [3:0] gnt,
    output logic       change,
    output logic       on_off,
    output logic       reject,
    output logic [7:0] active_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] gnt_nxt;
    logic       change_nxt, on_off_nxt, reject_nxt;
    logic [7:0] count_nxt;

    logic       found;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       bound;

    // Search starts at ptr and ascends modulo 4; first pending requester wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef IOT_ARB_REJECT_EN
    always_comb begin
        bound = dir[sel] ? (active_count == MAX_DEVICES) : (active_count == 8'd0);
    end
`else
    always_comb begin
        bound = 1'b0;
    end
`endif

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = '0;
        change_nxt = 1'b0;
        on_off_nxt = 1'b0;
        reject_nxt = 1'b0;
        count_nxt  = active_count;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = 4'b0001 << sel;
                    on_off_nxt = dir[sel];
                    change_nxt = !bound;
                    reject_nxt = bound;
                    ptr_nxt    = sel + 2'd1;
                end
            end
            GRANT: begin
                // Counter moves on the edge that closes the grant, alongside the monitor.
                state_nxt = IDLE;
                if (change) begin
                    count_nxt = on_off ? active_count + 8'd1 : active_count - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            change       <= 1'b0;
            on_off       <= 1'b0;
            reject       <= 1'b0;
            active_count <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            gnt          <= gnt_nxt;
            change       <= change_nxt;
            on_off       <= on_off_nxt;
            reject       <= reject_nxt;
            active_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Self-checking bench for iot_event_arbiter against a transaction-level model.
module tb_iot_event_arbiter;

    localparam logic [7:0] MAXD = 8'd3;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] gnt;
    logic       change;
    logic       on_off;
    logic       reject;
    logic [7:0] active_count;

    int tests;
    int fails;
    int mptr;
    int mcount;

    iot_event_arbiter #(.MAX_DEVICES(MAXD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .dir          (dir),
        .gnt          (gnt),
        .change       (change),
        .on_off       (on_off),
        .reject       (reject),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    {4'd0, gnt}, 8'd0);
        chk({tag, "_change"}, {7'd0, change}, 8'd0);
        chk({tag, "_on_off"}, {7'd0, on_off}, 8'd0);
        chk({tag, "_reject"}, {7'd0, reject}, 8'd0);
        chk({tag, "_count"},  active_count, 8'd0);
    endtask

    function automatic bit model_reject(input bit up);
`ifdef IOT_ARB_REJECT_EN
        return up ? (mcount == int'(MAXD)) : (mcount == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Presents a request set and serves it to completion, checking each grant.
    task automatic serve(input logic [3:0] r, input logic [3:0] d);
        logic [3:0] pend;
        logic [3:0] exp_gnt;
        int         idx;
        int         waited;
        bit         up;
        bit         rej;
        pend = r;
        req  = pend;
        dir  = d;
        while (pend != 4'd0) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (gnt == 4'd0 && waited < 4);
            idx = -1;
            for (int k = 0; k < 4; k++) begin
                if (idx < 0 && pend[(mptr + k) % 4]) idx = (mptr + k) % 4;
            end
            exp_gnt = 4'b0001 << idx;
            up  = d[idx];
            rej = model_reject(up);
            chk("latency", 8'(waited), 8'd1);
            chk("gnt", {4'd0, gnt}, {4'd0, exp_gnt});
            chk("on_off", {7'd0, on_off}, {7'd0, up});
            chk("change", {7'd0, change}, {7'd0, !rej});
            chk("reject", {7'd0, reject}, {7'd0, rej});
            chk("count_hold", active_count, 8'(mcount));
            mptr = (idx + 1) % 4;
            if (!rej) mcount = (mcount + (up ? 1 : -1)) & 255;
            pend[idx] = 1'b0;
            pend = pend & ~gnt;
            req  = pend;
            @(negedge clk);
            chk("gnt_end", {4'd0, gnt}, 8'd0);
            chk("change_end", {7'd0, change}, 8'd0);
            chk("count", active_count, 8'(mcount));
        end
    endtask

    task automatic idle_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("idle_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        mptr   = 0;
        mcount = 0;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        mptr   = 0;
        mcount = 0;
        rst_n  = 1'b0;
        req    = '0;
        dir    = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single up-event, then down to zero, then a down at zero boundary.
        serve(4'b0001, 4'b0001);
        serve(4'b0001, 4'b0000);
        serve(4'b0001, 4'b0000);
        serve(4'b0001, 4'b0001);

        // All four requesting from ptr 0: rotation 0,1,2,3; fourth up hits MAXD when rejecting.
        idle_reset();
        serve(4'b1111, 4'b1111);
        chk("ptr_wrap_cnt", active_count, 8'(mcount));

        // Move ptr to 2, then requesters 0 and 1 compete.
        serve(4'b0010, 4'b0000);
        serve(4'b0011, 4'b0011);

        // Reset asserted mid-grant aborts the event.
        idle_reset();
        req = 4'b0001;
        dir = 4'b0001;
        @(negedge clk);
        chk("abort_gnt", {4'd0, gnt}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        req    = '0;
        mptr   = 0;
        mcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_after", active_count, 8'd0);

        // Wrap below zero and above the top when counting is unconstrained.
        serve(4'b0100, 4'b0000);
        serve(4'b1000, 4'b1000);

        for (int n = 0; n < 40; n++) begin
            serve(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
        end

        // No requests: everything holds.
        req = '0;
        repeat (4) begin
            @(negedge clk);
            chk("hold_gnt", {4'd0, gnt}, 8'd0);
            chk("hold_count", active_count, 8'(mcount));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iot_event_arbiter.md
IOT_EVENT_ARBITER -- requirements
Module: iot_event_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_DEVICES, default 8'd255, meaning the upper bound of the active-device count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester event request, held high until granted.
REQ-005 The block SHALL have port dir, input, 4 bits: per-requester direction, 1 = device on, 0 = device off; valid while req is high.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant/acknowledge, one-cycle pulse.
REQ-007 The block SHALL have port change, output, 1 bit: counter-enable strobe to the device monitor.
REQ-008 The block SHALL have port on_off, output, 1 bit: count direction to the monitor, 1 = up, 0 = down.
REQ-009 The block SHALL have port reject, output, 1 bit: the granted request was dropped at a count boundary.
REQ-010 The block SHALL have port active_count, output, 8 bits: mirror of the monitor counter value.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and GRANT; the block SHALL reset into IDLE.
REQ-012 In IDLE, when any req bit is high, the block SHALL select one requester by round-robin, starting the search at pointer ptr[1:0] and ascending modulo 4.
REQ-013 On the next rising edge, the FSM SHALL enter GRANT, assert gnt[i] for the selected index i, drive on_off = dir[i] as sampled, and assert change = 1 unless the request is rejected.
REQ-014 GRANT SHALL last exactly one cycle, after which the FSM SHALL return to IDLE; the maximum grant rate is therefore one grant per two cycles.
REQ-015 A requester SHALL deassert req in the cycle after it sees gnt; req sampled in GRANT SHALL be ignored.
REQ-016 After a grant to index i, ptr SHALL become (i+1) mod 4.
REQ-017 active_count SHALL update on the clock edge that ends GRANT, in the same cycle as the monitor: +1 if on_off = 1, −1 if on_off = 0, and no change when change = 0.
REQ-018 gnt, change, on_off and reject SHALL be registered outputs, and SHALL be 0 in IDLE.
REQ-019 When req = 0, the FSM SHALL remain in IDLE with all outputs held.

Reset
REQ-020 Assertion of rst_n = 0 SHALL immediately force: state = IDLE, ptr = 0, gnt = 0, change = 0, on_off = 0, reject = 0, active_count = 0.
REQ-021 Reset asserted during GRANT SHALL abort the grant; the aborted event SHALL NOT be counted.
REQ-022 Operation SHALL resume on the first rising clk edge after rst_n = 1.

Configuration
REQ-023 With macro IOT_ARB_REJECT_EN defined, an up-request when active_count == MAX_DEVICES, or a down-request when active_count == 0, SHALL be granted with change = 0 and reject = 1, and active_count SHALL be unchanged.
REQ-024 With IOT_ARB_REJECT_EN undefined, reject SHALL be tied to 0, every grant SHALL assert change, and active_count SHALL wrap modulo 256 (255+1 → 0, 0−1 → 255).

Verification
REQ-025 Reset then req = 4'b0001, dir = 4'b0001 -> gnt = 0001, change = 1, on_off = 1 one cycle later; active_count = 1 afterwards.
REQ-026 req = 4'b1111 held, each granted bit dropped the cycle after its gnt -> grants in the order 0001, 0010, 0100, 1000, spaced 2 cycles apart; ptr wraps to 0.
REQ-027 ptr = 2, req = 4'b0011 -> first grant = 0001, then 0010.
REQ-028 REJECT_EN defined, active_count = 0, down-request -> gnt pulses, reject = 1, change = 0, active_count stays 0; undefined -> change = 1, active_count = 255.
REQ-029 rst_n pulled low during GRANT of an up-request -> all outputs 0 immediately; active_count = 0 and no count is registered.
REQ-030 REJECT_EN defined, MAX_DEVICES = 3, four up-requests -> active_count reaches 3, the fourth request returns reject = 1.
